// File: rtl/nvram_uploader.sv
// NVRAM uploader: serves HPS upload reads from a byte RAM while the core CPU is paused.
// Optional running checksum of delivered bytes is enabled with `define UPLOAD_CHECKSUM_EN.
module nvram_uploader #(
  parameter logic [7:0]  INDEX         = 8'd4,
  parameter int          ADDR_W        = 11,
  parameter logic [15:0] PAUSE_TIMEOUT = 16'hFFFF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_dout,
  output logic              pause_req,
  input  logic              pause_ack,
  output logic              busy,
  output logic              timeout,
  output logic [7:0]        checksum
);

  typedef enum logic [2:0] {IDLE, PAUSE, READY, FETCH, CAPTURE} state_t;

  state_t      state, state_nx;
  logic        session, sess_q;
  logic [15:0] pause_cnt;
  logic        pend_q, pend_nx, pend_oor_q;
  logic        rd_in_range, eff_pend, eff_oor;
  logic        start, req_take, din_load, set_timeout;
  logic [7:0]  din_nx;

  assign session     = ioctl_upload && (ioctl_index == INDEX);
  assign rd_in_range = (ioctl_addr >> ADDR_W) == 25'd0;

  // A request arriving on the same cycle PAUSE is left counts as the pending one.
  assign eff_pend = pend_q || ioctl_rd;
  assign eff_oor  = pend_q ? pend_oor_q : !rd_in_range;

  assign busy       = (state != IDLE);
  assign pause_req  = busy;
  assign ioctl_wait = (state == PAUSE) || (state == FETCH) || (state == CAPTURE);
  assign ram_rd     = (state == FETCH);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    state_nx    = state;
    pend_nx     = pend_q;
    start       = 1'b0;
    req_take    = 1'b0;
    din_load    = 1'b0;
    din_nx      = ioctl_din;
    set_timeout = 1'b0;
    if (state != IDLE && !session) begin
      state_nx = IDLE;
      pend_nx  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (session && !sess_q) begin
            state_nx = PAUSE;
            start    = 1'b1;
            req_take = ioctl_rd;
            pend_nx  = ioctl_rd;
          end
        end
        PAUSE: begin
          if (!pend_q && ioctl_rd) begin
            req_take = 1'b1;
            pend_nx  = 1'b1;
          end
          if (pause_ack || pause_cnt == PAUSE_TIMEOUT - 16'd1) begin
            set_timeout = !pause_ack;
            pend_nx     = 1'b0;
            if (eff_pend && !eff_oor) begin
              state_nx = FETCH;
            end else begin
              state_nx = READY;
              if (eff_pend) begin
                din_load = 1'b1;
                din_nx   = 8'hFF;
              end
            end
          end
        end
        READY: begin
          if (ioctl_rd) begin
            if (rd_in_range) begin
              req_take = 1'b1;
              state_nx = FETCH;
            end else begin
              din_load = 1'b1;
              din_nx   = 8'hFF;
            end
          end
        end
        FETCH:   state_nx = CAPTURE;
        CAPTURE: begin
          din_load = 1'b1;
          din_nx   = ram_dout;
          state_nx = READY;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      // NOTE: resets to 1 so a session already active when reset is released needs a fresh rising edge.
      sess_q     <= 1'b1;
      pause_cnt  <= 16'd0;
      pend_q     <= 1'b0;
      pend_oor_q <= 1'b0;
      ram_addr   <= '0;
      ioctl_din  <= 8'd0;
      timeout    <= 1'b0;
    end else begin
      state  <= state_nx;
      sess_q <= session;
      pend_q <= pend_nx;
      if (start)              pause_cnt <= 16'd0;
      else if (state == PAUSE) pause_cnt <= pause_cnt + 16'd1;
      if (req_take) begin
        ram_addr   <= ioctl_addr[ADDR_W-1:0];
        pend_oor_q <= !rd_in_range;
      end
      if (din_load)         ioctl_din <= din_nx;
      if (start)            timeout   <= 1'b0;
      else if (set_timeout) timeout   <= 1'b1;
    end
  end

`ifdef UPLOAD_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)      sum_q <= 8'd0;
    else if (start)    sum_q <= 8'd0;
    else if (din_load) sum_q <= sum_q + din_nx;
  end

  assign checksum = sum_q;
`else
  assign checksum = 8'd0;
`endif

endmodule

// File: tb/tb_nvram_uploader.sv
// Self-checking bench for nvram_uploader: expected bytes are queued at request time and
// compared when the DUT drops ioctl_wait; a behavioural RAM answers ram_rd one cycle later.
module tb_nvram_uploader;

  localparam int DEPTH = 2048;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [10:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_dout;
  logic        pause_req;
  logic        pause_ack;
  logic        busy;
  logic        timeout;
  logic [7:0]  checksum;

  logic [7:0]  mem [DEPTH];
  logic [7:0]  exp_q [$];
  int          ram_rd_cnt = 0;
  logic [10:0] last_ram_addr = '0;
  int          n_checks = 0;
  int          n_errors = 0;

  nvram_uploader dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .ram_addr     (ram_addr),
    .ram_rd       (ram_rd),
    .ram_dout     (ram_dout),
    .pause_req    (pause_req),
    .pause_ack    (pause_ack),
    .busy         (busy),
    .timeout      (timeout),
    .checksum     (checksum)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (ram_rd) begin
      ram_dout      <= mem[ram_addr];
      ram_rd_cnt    <= ram_rd_cnt + 1;
      last_ram_addr <= ram_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Wait (bounded) for ioctl_wait low, then compare the byte against the scoreboard head.
  task automatic collect(input string tag, output int lat);
    lat = 1;
    while (ioctl_wait && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_din"}, ioctl_din, exp_q.pop_front());
  endtask

  task automatic hps_read(input logic [24:0] a, input int exp_lat);
    int lat;
    exp_q.push_back(a < DEPTH ? mem[a[10:0]] : 8'hFF);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    collect("read", lat);
    check("read_latency", lat, exp_lat);
  endtask

  task automatic start_session(input int ack_dly);
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd4;
    tick();
    check("start_busy", busy, 1);
    check("start_pause_req", pause_req, 1);
    check("start_wait", ioctl_wait, 1);
    check("start_timeout", timeout, 0);
    if (ack_dly > 0) begin
      repeat (ack_dly - 1) tick();
      pause_ack = 1'b1;
      tick();
      check("ack_wait", ioctl_wait, 0);
    end
  endtask

  task automatic end_session();
    ioctl_upload = 1'b0;
    pause_ack    = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int lat, rd0, wait_hi;
    logic [7:0] prev_din;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i * 7 + 3);
    mem[11'h010] = 8'hA5;
    mem[11'h003] = 8'h3C;
    mem[11'h100] = 8'h80;
    mem[11'h101] = 8'h90;
    mem[11'h102] = 8'h01;

    reset_n = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd0; ioctl_rd = 1'b0;
    ioctl_addr = '0; pause_ack = 1'b0;
    repeat (3) tick();
    check("rst_din", ioctl_din, 0);
    check("rst_wait", ioctl_wait, 0);
    check("rst_ram_rd", ram_rd, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_pause_req", pause_req, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    check("rst_checksum", checksum, 0);
    reset_n = 1'b1;
    tick();

    // Wrong index never starts a session.
    ioctl_upload = 1'b1; ioctl_index = 8'd5;
    repeat (3) tick();
    check("wrong_index_busy", busy, 0);
    ioctl_upload = 1'b0;
    tick();

    // Session A: ack after 5 cycles, in-range, out-of-range and boundary reads.
    start_session(5);
    rd0 = ram_rd_cnt;
    exp_q.push_back(mem[11'h010]);
    ioctl_addr = 25'h010; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    wait_hi = 0;
    for (int c = 0; c < 2; c++) begin
      if (ioctl_wait) wait_hi++;
      tick();
    end
    check("a5_wait_cycles", wait_hi, 2);
    check("a5_wait_low", ioctl_wait, 0);
    check("a5_din", ioctl_din, exp_q.pop_front());
    check("a5_ram_rd_count", ram_rd_cnt - rd0, 1);
    check("a5_ram_addr", last_ram_addr, 11'h010);
    rd0 = ram_rd_cnt;
    hps_read(25'h800, 1);
    hps_read(25'h1FFFFFF, 1);
    check("oor_ram_rd_count", ram_rd_cnt - rd0, 0);
    hps_read(25'h7FF, 3);
    hps_read(25'h000, 3);

    // Drop the session while in FETCH.
    prev_din   = ioctl_din;
    ioctl_addr = 25'h020; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    check("drop_in_fetch_ram_rd", ram_rd, 1);
    ioctl_upload = 1'b0;
    tick();
    check("drop_pause_req", pause_req, 0);
    check("drop_wait", ioctl_wait, 0);
    check("drop_busy", busy, 0);
    check("drop_ram_rd", ram_rd, 0);
    check("drop_din_kept", ioctl_din, prev_din);
    end_session();

    // Session B: read issued during PAUSE is held; a second one is ignored.
    start_session(0);
    rd0 = ram_rd_cnt;
    exp_q.push_back(mem[11'h003]);
    ioctl_addr = 25'h003; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    tick();
    ioctl_addr = 25'h005; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    check("pend_still_wait", ioctl_wait, 1);
    pause_ack = 1'b1;
    tick();
    collect("pend", lat);
    check("pend_ram_addr", last_ram_addr, 11'h003);
    check("pend_ram_rd_count", ram_rd_cnt - rd0, 1);
    end_session();

    // Session C: start coincides with an out-of-range read.
    rd0 = ram_rd_cnt;
    exp_q.push_back(8'hFF);
    ioctl_upload = 1'b1; ioctl_index = 8'd4; ioctl_addr = 25'h800; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    check("simul_wait", ioctl_wait, 1);
    pause_ack = 1'b1;
    tick();
    collect("simul", lat);
    check("simul_ram_rd_count", ram_rd_cnt - rd0, 0);
    end_session();

    // Session D: checksum, then reset mid-session.
    start_session(2);
    hps_read(25'h100, 3);
    hps_read(25'h101, 3);
    hps_read(25'h102, 3);
`ifdef UPLOAD_CHECKSUM_EN
    check("checksum_sum", checksum, 8'h11);
`else
    check("checksum_off", checksum, 8'h00);
`endif
    reset_n = 1'b0;
    #2;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pause_req", pause_req, 0);
    check("mid_rst_din", ioctl_din, 0);
    check("mid_rst_checksum", checksum, 0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("no_restart_busy", busy, 0);
    check("no_restart_pause_req", pause_req, 0);
    end_session();

    // Session E: pause_ack never arrives.
    start_session(0);
    repeat (65534) tick();
    check("pre_timeout_flag", timeout, 0);
    check("pre_timeout_wait", ioctl_wait, 1);
    tick();
    check("timeout_flag", timeout, 1);
    check("timeout_ready_wait", ioctl_wait, 0);
    check("timeout_pause_req", pause_req, 1);
    check("timeout_busy", busy, 1);
    hps_read(25'h010, 3);
    check("timeout_sticky", timeout, 1);
    end_session();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
